text_line_scroller: RTL and testbench

Upstream feeder for the glyph renderer (`letterGen`). It holds a message of up to 16 character codes and maps the current VGA pixel (x, y) to a glyph code and glyph bounding box (`left`, `top`, `right`, `bot`). The message is loaded through a valid/ready write port into a shadow buffer and swapped into the active buffer at a frame boundary. The text can scroll horizontally through a fixed window, advancing one pixel per `SCROLL_DIV` frames.

---
 rtl/text_line_scroller.sv | 167 ++++++++++++++++
 tb/tb_text_line_scroller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/text_line_scroller.sv
// Maps VGA pixel (x,y) to a glyph code and box from a 16-char double-buffered, scrollable message.
// All pixel outputs are registered (1-cycle latency); wr_ready is low while a loaded message waits for frame_start.
module text_line_scroller #(
  parameter int X0         = 64,
  parameter int Y0         = 200,
  parameter int GLYPH_W    = 15,
  parameter int GLYPH_H    = 20,
  parameter int BLANK_CODE = 38,
  parameter int SCROLL_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_start,
  input  logic       scroll_en,
  input  logic       wr_valid,
  input  logic [5:0] wr_code,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic [9:0] x_q,
  output logic [9:0] y_q,
  output logic [9:0] left,
  output logic [9:0] top,
  output logic [9:0] right,
  output logic [9:0] bot,
  output logic [5:0] letterSelect
);

  localparam logic [10:0] XLO      = 11'(X0);
  localparam logic [10:0] XHI      = 11'(X0 + 256);
  localparam logic [10:0] YLO      = 11'(Y0);
  localparam logic [10:0] YHI      = 11'(Y0 + GLYPH_H);
  localparam logic [9:0]  TOP_V    = 10'(Y0);
  localparam logic [9:0]  BOT_V    = 10'(Y0 + GLYPH_H);
  localparam logic [9:0]  W_V      = 10'(GLYPH_W);
  localparam logic [5:0]  BLANK    = 6'(BLANK_CODE);
  localparam logic [7:0]  X0_8     = 8'(X0);
  localparam logic [7:0]  DIV_LAST = 8'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOADING, PENDING} state_t;

  state_t     state, state_nxt;
  logic [5:0] shadow [16];
  logic [5:0] active [16];
  logic [3:0] wptr;
  logic [4:0] slen, alen;
  logic [7:0] off, fdiv;

  logic       pending, wr_acc, wr_term, first_wr, swap, step;
  logic       in_win;
  logic [7:0] v;
  logic [3:0] idx, col;
  logic [9:0] left_nxt;

  assign pending  = (state == PENDING);
  assign wr_ready = !pending;
  assign wr_acc   = wr_valid & wr_ready;
  assign wr_term  = wr_acc & (wr_last | (wptr == 4'd15));
  // pending is the registered flag, so a terminating write in a frame_start cycle waits a frame
  assign swap     = frame_start & pending;
  assign step     = frame_start & scroll_en & !swap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    first_wr  = 1'b0;
    case (state)
      IDLE: begin
        first_wr = wr_acc;
        if (wr_acc) state_nxt = wr_term ? PENDING : LOADING;
      end
      LOADING: if (wr_term) state_nxt = PENDING;
      PENDING: if (swap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= BLANK;
      wptr <= 4'd0;
      slen <= 5'd0;
    end else if (wr_acc) begin
      if (first_wr) begin
        for (int i = 1; i < 16; i++) shadow[i] <= BLANK;
      end
      shadow[wptr] <= wr_code;
      if (wr_term) begin
        slen <= {1'b0, wptr} + 5'd1;
        wptr <= 4'd0;
      end else begin
        wptr <= wptr + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) active[i] <= BLANK;
      alen <= 5'd0;
    end else if (swap) begin
      for (int i = 0; i < 16; i++) active[i] <= shadow[i];
      alen <= slen;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off  <= 8'd0;
      fdiv <= 8'd0;
    end else if (swap) begin
      off  <= 8'd0;
      fdiv <= 8'd0;
    end else if (step) begin
      if (fdiv == DIV_LAST) begin
        fdiv <= 8'd0;
        off  <= off + 8'd1;
      end else begin
        fdiv <= fdiv + 8'd1;
      end
    end
  end

  // 8-bit subtraction keeps the window-relative position modulo 256
  always_comb begin
    in_win   = ({1'b0, x} >= XLO) && ({1'b0, x} < XHI) &&
               ({1'b0, y} >= YLO) && ({1'b0, y} < YHI);
    v        = x[7:0] - X0_8 + off;
    idx      = v[7:4];
    col      = v[3:0];
    left_nxt = x - {6'd0, col};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      left         <= 10'd0;
      right        <= 10'd0;
      top          <= 10'd0;
      bot          <= 10'd0;
      letterSelect <= BLANK;
    end else begin
      x_q <= x;
      y_q <= y;
      if (in_win) begin
        left         <= left_nxt;
        right        <= left_nxt + W_V;
        top          <= TOP_V;
        bot          <= BOT_V;
        letterSelect <= ({1'b0, idx} < alen) ? active[idx] : BLANK;
      end else begin
        left         <= 10'd0;
        right        <= 10'd0;
        top          <= 10'd0;
        bot          <= 10'd0;
        letterSelect <= BLANK;
      end
    end
  end

endmodule

// File: tb/tb_text_line_scroller.sv
// Directed bench for text_line_scroller: load/swap, backpressure, scroll, window edges, full message.
module tb_text_line_scroller;

  logic       clk, reset_n;
  logic [9:0] x, y;
  logic       frame_start, scroll_en, wr_valid, wr_last, wr_ready;
  logic [5:0] wr_code, letterSelect;
  logic [9:0] x_q, y_q, left, top, right, bot;

  int checks = 0;
  int errors = 0;

  text_line_scroller #(.SCROLL_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y),
    .frame_start(frame_start), .scroll_en(scroll_en),
    .wr_valid(wr_valid), .wr_code(wr_code), .wr_last(wr_last), .wr_ready(wr_ready),
    .x_q(x_q), .y_q(y_q), .left(left), .top(top), .right(right), .bot(bot),
    .letterSelect(letterSelect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] code, input logic last);
    wr_valid = 1'b1; wr_code = code; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py);
    x = px; y = py;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [5:0] code, input logic [9:0] l,
                         input logic [9:0] r, input logic [9:0] t, input logic [9:0] b);
    chk({tag, ".code"},  letterSelect, code);
    chk({tag, ".left"},  left, l);
    chk({tag, ".right"}, right, r);
    chk({tag, ".top"},   top, t);
    chk({tag, ".bot"},   bot, b);
  endtask

  initial begin
    reset_n = 1'b0; x = '0; y = '0; frame_start = 1'b0; scroll_en = 1'b0;
    wr_valid = 1'b0; wr_code = '0; wr_last = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst.wr_ready", wr_ready, 1);
    chk("rst.code", letterSelect, 38);

    // partial load plus an in-window pixel, then reset asynchronously between edges
    wr(6'd5, 1'b0);
    pix(10'd64, 10'd200);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.wr_ready", wr_ready, 1);
    chk_out("arst", 6'd38, 10'd0, 10'd0, 10'd0, 10'd0);
    chk("arst.x_q", x_q, 0);
    chk("arst.y_q", y_q, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // load and swap
    wr(6'd1, 1'b0); wr(6'd2, 1'b0); wr(6'd3, 1'b1);
    chk("load.wr_ready_low", wr_ready, 0);
    pix(10'd64, 10'd200);
    chk("preswap.code", letterSelect, 38);
    frame();
    chk("swap.wr_ready_high", wr_ready, 1);
    pix(10'd64, 10'd200);
    chk_out("x64", 6'd1, 10'd64, 10'd79, 10'd200, 10'd220);
    chk("x64.x_q", x_q, 64);
    chk("x64.y_q", y_q, 200);
    pix(10'd85, 10'd200);
    chk_out("x85", 6'd2, 10'd80, 10'd95, 10'd200, 10'd220);
    pix(10'd112, 10'd200);
    chk("x112.code", letterSelect, 38);

    // window edges
    pix(10'd63, 10'd200);
    chk_out("x63", 6'd38, 10'd0, 10'd0, 10'd0, 10'd0);
    pix(10'd320, 10'd200);
    chk_out("x320", 6'd38, 10'd0, 10'd0, 10'd0, 10'd0);
    pix(10'd100, 10'd220);
    chk_out("y220", 6'd38, 10'd0, 10'd0, 10'd0, 10'd0);
    pix(10'd319, 10'd219);
    chk_out("x319y219", 6'd38, 10'd304, 10'd319, 10'd200, 10'd220);

    // backpressure: held writes while pending are ignored
    wr(6'd7, 1'b0); wr(6'd8, 1'b1);
    wr_valid = 1'b1; wr_code = 6'd9;
    for (int i = 0; i < 10; i++) tick();
    chk("bp.wr_ready_low", wr_ready, 0);
    wr_valid = 1'b0;
    pix(10'd64, 10'd200);
    chk("bp.old_active", letterSelect, 1);
    frame();
    chk("bp.wr_ready_high", wr_ready, 1);
    pix(10'd64, 10'd200);  chk("bp.c0", letterSelect, 7);
    pix(10'd80, 10'd200);  chk("bp.c1", letterSelect, 8);
    pix(10'd96, 10'd200);  chk("bp.c2", letterSelect, 38);

    // terminating write in the frame_start cycle: no swap until next frame
    wr(6'd4, 1'b0);
    wr_valid = 1'b1; wr_code = 6'd5; wr_last = 1'b1; frame_start = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; frame_start = 1'b0;
    chk("same.wr_ready_low", wr_ready, 0);
    pix(10'd64, 10'd200);  chk("same.noswap", letterSelect, 7);
    frame();
    chk("same.wr_ready_high", wr_ready, 1);
    pix(10'd64, 10'd200);  chk("same.c0", letterSelect, 4);
    pix(10'd80, 10'd200);  chk("same.c1", letterSelect, 5);

    // frame_start while loading leaves the load intact
    wr(6'd10, 1'b0);
    frame();
    chk("ldfs.wr_ready", wr_ready, 1);
    wr(6'd11, 1'b1);
    frame();
    pix(10'd64, 10'd200);  chk("ldfs.c0", letterSelect, 10);
    pix(10'd80, 10'd200);  chk("ldfs.c1", letterSelect, 11);

    // scroll with SCROLL_DIV = 1
    wr(6'd1, 1'b0); wr(6'd2, 1'b0); wr(6'd3, 1'b1);
    frame();
    scroll_en = 1'b1;
    for (int i = 0; i < 16; i++) frame();
    pix(10'd64, 10'd200);
    chk("scr16.code", letterSelect, 2);
    chk("scr16.left", left, 64);
    for (int i = 0; i < 240; i++) frame();
    pix(10'd64, 10'd200);
    chk("scr256.code", letterSelect, 1);
    chk("scr256.left", left, 64);
    for (int i = 0; i < 15; i++) frame();
    pix(10'd64, 10'd200);
    chk_out("scr15", 6'd1, 10'd49, 10'd64, 10'd200, 10'd220);
    scroll_en = 1'b0;
    frame();
    pix(10'd64, 10'd200);
    chk("scrhold.left", left, 49);

    // full 16-character message, no wr_last
    for (int i = 0; i < 15; i++) wr(6'(i), 1'b0);
    chk("full15.wr_ready", wr_ready, 1);
    wr(6'd15, 1'b0);
    chk("full16.wr_ready", wr_ready, 0);
    frame();
    chk("full.swap_ready", wr_ready, 1);
    pix(10'd304, 10'd200);
    chk_out("full.x304", 6'd15, 10'd304, 10'd319, 10'd200, 10'd220);
    pix(10'd64, 10'd200);
    chk("full.x64", letterSelect, 0);
    pix(10'd200, 10'd210);
    chk("full.x200", letterSelect, 8);
    chk("full.x200left", left, 192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
